// File: rtl/alu_seq_if.sv
// rtl/alu_seq_if.sv - ALU pin bundle between the sequencer (master) and the 16-bit accumulator ALU (slave)
interface alu_seq_if;
    logic [4:0]  alu_opcode;
    logic [15:0] alu_operand;
    logic        alu_read;
    logic        alu_write;
    logic [15:0] alu_accin;

    modport master (
        output alu_opcode,
        output alu_operand,
        output alu_read,
        output alu_write,
        input  alu_accin
    );

    modport slave (
        input  alu_opcode,
        input  alu_operand,
        input  alu_read,
        input  alu_write,
        output alu_accin
    );
endinterface

// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - 32-bit op sequencer over a 16-bit accumulator ALU; ALU_SEQ_LOGIC_EN enables AND32/OR32
module alu_seq (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [1:0]  cmd,
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [31:0] result,
    alu_seq_if.master   bus
);

    localparam logic [1:0] CMD_ADD = 2'b00;
    localparam logic [1:0] CMD_SUB = 2'b01;
`ifdef ALU_SEQ_LOGIC_EN
    localparam logic [1:0] CMD_AND = 2'b10;
    localparam logic [1:0] CMD_OR  = 2'b11;
`endif

    localparam logic [4:0] OPC_NOP = 5'b00000;
    localparam logic [4:0] OPC_ADD = 5'b00001;
    localparam logic [4:0] OPC_SUB = 5'b00010;
    localparam logic [4:0] OPC_ADC = 5'b01101;
    localparam logic [4:0] OPC_SBB = 5'b01110;
`ifdef ALU_SEQ_LOGIC_EN
    localparam logic [4:0] OPC_AND = 5'b00111;
    localparam logic [4:0] OPC_OR  = 5'b01000;
`endif

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WR_LO = 3'd1,
        S_OP_LO = 3'd2,
        S_RD_LO = 3'd3,
        S_WR_HI = 3'd4,
        S_OP_HI = 3'd5,
        S_RD_HI = 3'd6,
        S_DONE  = 3'd7
    } state_t;

    state_t      state_q, state_d;
    logic [1:0]  cmd_q;
    logic [31:0] a_q;
    logic [31:0] b_q;
    logic [31:0] result_q;
    logic        err_q;
    logic        cmd_legal;
    logic        accept;

    // Logic commands exist only in the full build; otherwise the top cmd bit marks an illegal request.
`ifdef ALU_SEQ_LOGIC_EN
    assign cmd_legal = 1'b1;
`else
    assign cmd_legal = ~cmd[1];
`endif

    assign accept = (state_q == S_IDLE) && start && cmd_legal;

    // Opcode for one half; the high half chains through the ALU carry for arithmetic commands.
    function automatic logic [4:0] half_opcode(input logic [1:0] c, input logic hi);
        logic [4:0] opc;
        opc = OPC_NOP;
        case (c)
            CMD_ADD: opc = hi ? OPC_ADC : OPC_ADD;
            CMD_SUB: opc = hi ? OPC_SBB : OPC_SUB;
`ifdef ALU_SEQ_LOGIC_EN
            CMD_AND: opc = OPC_AND;
            CMD_OR:  opc = OPC_OR;
`endif
            default: opc = OPC_NOP;
        endcase
        return opc;
    endfunction

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: only IDLE waits on input, the bus walk is fixed length.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  state_d = accept ? S_WR_LO : S_IDLE;
            S_WR_LO: state_d = S_OP_LO;
            S_OP_LO: state_d = S_RD_LO;
            S_RD_LO: state_d = S_WR_HI;
            S_WR_HI: state_d = S_OP_HI;
            S_OP_HI: state_d = S_RD_HI;
            S_RD_HI: state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Command and operand capture on an accepted start; held for the whole sequence.
    always_ff @(posedge clk) begin
        if (rst) begin
            cmd_q <= 2'b00;
            a_q   <= 32'd0;
            b_q   <= 32'd0;
        end else if (accept) begin
            cmd_q <= cmd;
            a_q   <= op_a;
            b_q   <= op_b;
        end
    end

    // Result halves are captured from the accumulator at the end of each read state.
    always_ff @(posedge clk) begin
        if (rst) begin
            result_q <= 32'd0;
        end else if (state_q == S_RD_LO) begin
            result_q[15:0] <= bus.alu_accin;
        end else if (state_q == S_RD_HI) begin
            result_q[31:16] <= bus.alu_accin;
        end
    end

    // Rejection pulse, one cycle after an illegal start seen in IDLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= (state_q == S_IDLE) && start && !cmd_legal;
        end
    end

    // Moore decode of status and ALU pins; writes always carry NOP so the ALU op cannot override them.
    always_comb begin
        busy            = (state_q != S_IDLE);
        done            = (state_q == S_DONE);
        bus.alu_opcode  = OPC_NOP;
        bus.alu_operand = 16'd0;
        bus.alu_read    = 1'b0;
        bus.alu_write   = 1'b0;
        case (state_q)
            S_WR_LO: begin
                bus.alu_write   = 1'b1;
                bus.alu_operand = a_q[15:0];
            end
            S_OP_LO: begin
                bus.alu_opcode  = half_opcode(cmd_q, 1'b0);
                bus.alu_operand = b_q[15:0];
            end
            S_RD_LO: bus.alu_read = 1'b1;
            S_WR_HI: begin
                bus.alu_write   = 1'b1;
                bus.alu_operand = a_q[31:16];
            end
            S_OP_HI: begin
                bus.alu_opcode  = half_opcode(cmd_q, 1'b1);
                bus.alu_operand = b_q[31:16];
            end
            S_RD_HI: bus.alu_read = 1'b1;
            default: ;
        endcase
    end

    assign err    = err_q;
    assign result = result_q;

endmodule

// File: tb/tb_alu_seq.sv
// tb/tb_alu_seq.sv - randomized self-checking bench for alu_seq with a behavioural ALU and 32-bit reference
module tb_alu_seq;

    logic        clk;
    logic        rst;
    logic        start;
    logic [1:0]  cmd;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        busy;
    logic        done;
    logic        err;
    logic [31:0] result;

    int total;
    int bad;

    alu_seq_if bus_if ();

    alu_seq dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .cmd    (cmd),
        .op_a   (op_a),
        .op_b   (op_b),
        .busy   (busy),
        .done   (done),
        .err    (err),
        .result (result),
        .bus    (bus_if.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural 16-bit accumulator ALU with a carry/borrow flag; write touches only the accumulator.
    logic [15:0] alu_acc;
    logic        alu_c;
    initial begin
        alu_acc = 16'd0;
        alu_c   = 1'b0;
    end
    always @(posedge clk) begin
        if (bus_if.alu_write) begin
            alu_acc <= bus_if.alu_operand;
        end else begin
            case (bus_if.alu_opcode)
                5'd1:  {alu_c, alu_acc} <= {1'b0, alu_acc} + {1'b0, bus_if.alu_operand};
                5'd13: {alu_c, alu_acc} <= {1'b0, alu_acc} + {1'b0, bus_if.alu_operand} + {16'd0, alu_c};
                5'd2:  {alu_c, alu_acc} <= {1'b0, alu_acc} - {1'b0, bus_if.alu_operand};
                5'd14: {alu_c, alu_acc} <= {1'b0, alu_acc} - {1'b0, bus_if.alu_operand} - {16'd0, alu_c};
                5'd7:  alu_acc <= alu_acc & bus_if.alu_operand;
                5'd8:  alu_acc <= alu_acc | bus_if.alu_operand;
                default: ;
            endcase
        end
    end
    assign bus_if.alu_accin = bus_if.alu_read ? alu_acc : 16'hDEAD;

    // Protocol monitor: a write cycle must carry the NOP opcode.
    always @(negedge clk) begin
        if (!rst && bus_if.alu_write === 1'b1) begin
            total++;
            if (bus_if.alu_opcode !== 5'd0) begin
                bad++;
                $display("FAIL write_with_op: opcode=%b required=00000", bus_if.alu_opcode);
            end
        end
    end

    function automatic logic cmd_ok(input logic [1:0] c);
`ifdef ALU_SEQ_LOGIC_EN
        return 1'b1;
`else
        return !c[1];
`endif
    endfunction

    function automatic logic [31:0] ref_result(input logic [1:0] c, input logic [31:0] a, input logic [31:0] b);
        case (c)
            2'b00:   return a + b;
            2'b01:   return a - b;
            2'b10:   return a & b;
            default: return a | b;
        endcase
    endfunction

    function automatic logic [4:0] ref_opc(input logic [1:0] c, input logic hi);
        case (c)
            2'b00:   return hi ? 5'b01101 : 5'b00001;
            2'b01:   return hi ? 5'b01110 : 5'b00010;
            2'b10:   return 5'b00111;
            default: return 5'b01000;
        endcase
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Runs one legal command from IDLE, checking every cycle of the bus walk and the final result.
    task automatic run_op(input logic [1:0] c, input logic [31:0] a, input logic [31:0] b, input string nm);
        logic [24:0] got, exp;
        logic [31:0] want;
        want  = ref_result(c, a, b);
        start = 1'b1;
        cmd   = c;
        op_a  = a;
        op_b  = b;
        cyc();
        start = 1'b0;
        op_a  = $urandom;
        op_b  = $urandom;
        for (int k = 1; k <= 7; k++) begin
            exp = '0;
            exp[24] = 1'b1;
            exp[23] = (k == 7);
            exp[22] = (k == 1 || k == 4);
            exp[21] = (k == 3 || k == 6);
            if (k == 2) exp[20:16] = ref_opc(c, 1'b0);
            if (k == 5) exp[20:16] = ref_opc(c, 1'b1);
            if (k == 1) exp[15:0] = a[15:0];
            if (k == 2) exp[15:0] = b[15:0];
            if (k == 4) exp[15:0] = a[31:16];
            if (k == 5) exp[15:0] = b[31:16];
            got = {busy, done, bus_if.alu_write, bus_if.alu_read, bus_if.alu_opcode, bus_if.alu_operand};
            total++;
            if (got !== exp) begin
                bad++;
                $display("FAIL %s_cycle%0d: busy/done/wr/rd/opc/operand=%h required=%h", nm, k, got, exp);
            end
            if (k == 7) begin
                total++;
                if (result !== want || err !== 1'b0) begin
                    bad++;
                    $display("FAIL %s_result: result=%h err=%b required=%h err=0", nm, result, err, want);
                end
            end
            cyc();
        end
        total++;
        if (busy !== 1'b0 || result !== want) begin
            bad++;
            $display("FAIL %s_after: busy=%b result=%h required busy=0 result=%h", nm, busy, result, want);
        end
    endtask

    // Illegal command from IDLE: one err pulse, no bus activity, result untouched.
    task automatic run_reject(input logic [1:0] c, input logic [31:0] a, input logic [31:0] b, input string nm);
        logic [31:0] held;
        held  = result;
        start = 1'b1;
        cmd   = c;
        op_a  = a;
        op_b  = b;
        cyc();
        start = 1'b0;
        total++;
        if (err !== 1'b1 || busy !== 1'b0 || bus_if.alu_write !== 1'b0 || bus_if.alu_read !== 1'b0 ||
            bus_if.alu_opcode !== 5'd0 || result !== held) begin
            bad++;
            $display("FAIL %s_pulse: err=%b busy=%b wr=%b rd=%b opc=%b result=%h required err=1 busy=0 idle bus result=%h",
                     nm, err, busy, bus_if.alu_write, bus_if.alu_read, bus_if.alu_opcode, result, held);
        end
        cyc();
        total++;
        if (err !== 1'b0 || busy !== 1'b0 || result !== held) begin
            bad++;
            $display("FAIL %s_end: err=%b busy=%b result=%h required err=0 busy=0 result=%h", nm, err, busy, result, held);
        end
    endtask

    task automatic test_reset();
        rst   = 1'b1;
        start = 1'b0;
        cmd   = 2'b00;
        op_a  = 32'd0;
        op_b  = 32'd0;
        repeat (3) cyc();
        rst = 1'b0;
        total++;
        if ({busy, done, err, result, bus_if.alu_opcode, bus_if.alu_operand, bus_if.alu_read, bus_if.alu_write} !== '0) begin
            bad++;
            $display("FAIL reset_state: busy=%b done=%b err=%b result=%h opc=%b operand=%h rd=%b wr=%b required all zero",
                     busy, done, err, result, bus_if.alu_opcode, bus_if.alu_operand, bus_if.alu_read, bus_if.alu_write);
        end
    endtask

    task automatic test_directed();
        run_op(2'b00, 32'h0001_FFFF, 32'h0000_0001, "add_carry");
        run_op(2'b01, 32'h0001_0000, 32'h0000_0001, "sub_borrow");
        run_op(2'b00, 32'hFFFF_FFFF, 32'h0000_0001, "add_wrap");
        run_op(2'b01, 32'h0000_0000, 32'h0000_0001, "sub_wrap");
    endtask

    task automatic test_logic();
`ifdef ALU_SEQ_LOGIC_EN
        run_op(2'b10, 32'hF0F0_1234, 32'hFF00_00FF, "and32");
        run_op(2'b11, 32'hF0F0_1234, 32'h0F00_00FF, "or32");
`else
        run_reject(2'b10, 32'hF0F0_1234, 32'hFF00_00FF, "and32_rej");
        run_reject(2'b11, 32'hF0F0_1234, 32'h0F00_00FF, "or32_rej");
`endif
    endtask

    task automatic test_ignore_start();
        logic [31:0] a, b, want;
        a     = 32'h1234_8000;
        b     = 32'h0FFF_8000;
        want  = a + b;
        start = 1'b1;
        cmd   = 2'b00;
        op_a  = a;
        op_b  = b;
        cyc();
        start = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            start = (k == 3);
            cmd   = 2'b01;
            op_a  = $urandom;
            op_b  = $urandom;
            if (k == 7) begin
                total++;
                if (done !== 1'b1 || result !== want) begin
                    bad++;
                    $display("FAIL ignore_start: done=%b result=%h required done=1 result=%h", done, result, want);
                end
            end
            cyc();
        end
        start = 1'b0;
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL ignore_start_idle: busy=%b required 0", busy);
        end
    endtask

    task automatic test_mid_reset();
        start = 1'b1;
        cmd   = 2'b00;
        op_a  = 32'h5555_AAAA;
        op_b  = 32'h1111_2222;
        cyc();
        start = 1'b0;
        repeat (4) cyc();
        total++;
        if (bus_if.alu_opcode !== 5'b01101) begin
            bad++;
            $display("FAIL mid_reset_in_op_hi: opc=%b required 01101", bus_if.alu_opcode);
        end
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        total++;
        if ({busy, done, err, result, bus_if.alu_opcode, bus_if.alu_operand, bus_if.alu_read, bus_if.alu_write} !== '0) begin
            bad++;
            $display("FAIL mid_reset: busy=%b done=%b err=%b result=%h opc=%b operand=%h rd=%b wr=%b required all zero",
                     busy, done, err, result, bus_if.alu_opcode, bus_if.alu_operand, bus_if.alu_read, bus_if.alu_write);
        end
        run_op(2'b01, 32'h0000_0005, 32'h0000_0007, "after_reset");
    endtask

    task automatic test_random();
        logic [1:0]  c;
        logic [31:0] a, b;
        for (int n = 0; n < 24; n++) begin
            c = 2'($urandom_range(0, 3));
            a = $urandom;
            b = $urandom;
            if (n % 5 == 0) a[15:0] = 16'hFFFF;
            if (cmd_ok(c)) run_op(c, a, b, "rand");
            else run_reject(c, a, b, "rand_rej");
            repeat ($urandom_range(0, 2)) cyc();
        end
    endtask

    task automatic test_back_to_back();
        run_op(2'b00, 32'h0000_FFFF, 32'h0000_FFFF, "b2b_0");
        run_op(2'b01, 32'h8000_0000, 32'h0000_0001, "b2b_1");
        run_op(2'b00, 32'h7FFF_FFFF, 32'h0000_0001, "b2b_2");
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_directed();
        test_logic();
        test_ignore_start();
        test_mid_reset();
        test_random();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_seq.md
# alu_seq

Bus master for the 16-bit accumulator ALU: executes one 32-bit operation per command by driving the ALU's `opcode`/`operand`/`read`/`write` pins through a fixed low-half/high-half sequence and capturing `accout` into a 32-bit result. It sits between the control unit and the ALU. It uses the ALU's internal carry bit (ADD→ADC, SUB→SBB) to chain the two halves, so 32-bit arithmetic needs no extra datapath.

## Interface
Parameters:
- none (widths fixed by the ALU bus: 5-bit opcode, 16-bit data)

Ports:
- `clk`  in  1  clock; all state changes on posedge
- `rst`  in  1  synchronous, active-high reset
- `start`  in  1  command request; sampled in IDLE only
- `cmd`  in  2  00 ADD32, 01 SUB32, 10 AND32, 11 OR32
- `op_a`  in  32  first operand (accumulator side)
- `op_b`  in  32  second operand
- `busy`  out  1  high in every non-IDLE state
- `done`  out  1  one-cycle pulse, result valid
- `err`  out  1  one-cycle pulse, command rejected
- `result`  out  32  last completed result, held until the next accepted start
- `alu_opcode`  out  5  to ALU `opcode`
- `alu_operand`  out  16  to ALU `operand`
- `alu_read`  out  1  to ALU `read`
- `alu_write`  out  1  to ALU `write`
- `alu_accin`  in  16  from ALU `accout`; valid only while `alu_read`=1

## Operation
- FSM states: IDLE, WR_LO, OP_LO, RD_LO, WR_HI, OP_HI, RD_HI, DONE. Transitions are unconditional after leaving IDLE. DONE→IDLE.
- IDLE with `start`=1 and a legal `cmd`: latch `op_a`, `op_b`, `cmd`; go to WR_LO.
- Bus outputs are decoded from state (Moore):
  - WR_x: `alu_write`=1, operand = A half, opcode NOP (00000).
  - OP_x: `alu_write`=0, opcode per table below, operand = B half.
  - RD_x: `alu_read`=1, opcode NOP.
  - All other states: opcode NOP, operand 0, `alu_read`=0, `alu_write`=0.
- `alu_write` and a non-NOP opcode are never asserted in the same cycle, because the ALU's op would override the write.
- Opcodes per half:
  - ADD32: lo 00001 ADD, hi 01101 ADC
  - SUB32: lo 00010 SUB, hi 01110 SBB
  - AND32: 00111 on both halves
  - OR32: 01000 on both halves
- WR_HI relies on the ALU write updating bits [15:0] only, which preserves the carry produced in OP_LO.
- Posedge ending RD_LO: `result[15:0]` ← `alu_accin`. Posedge ending RD_HI: `result[31:16]` ← `alu_accin`.
- Arithmetic is modulo 2^32. No carry-out or overflow is reported.
- `start` outside IDLE is ignored. No queueing.
- Reset (any state, including mid-sequence): state→IDLE; `result`=0; `busy`=`done`=`err`=0; bus outputs go to idle values (NOP, 0, 0, 0) from the cycle after the reset edge. ALU carry is not cleared; every sequence rewrites it in OP_LO before use.

## Timing
- Start accepted in cycle 0. Bus states occupy cycles 1–6. DONE in cycle 7: `done`=1 and the full `result` is valid.
- `busy`=1 in cycles 1–7. A new start is accepted in cycle 8 at the earliest, for a throughput of one op per 8 cycles.
- `err` goes high in the cycle after the rejected start, for exactly one cycle. State stays IDLE and `busy` stays 0.
- `alu_accin` is sampled only at the posedges ending RD_LO and RD_HI.

## Configuration
- `ALU_SEQ_LOGIC_EN` defined: cmd 10/11 (AND32/OR32) are legal and sequenced as above.
- Undefined: cmd 10/11 are illegal. They produce an `err` pulse, with no bus activity and `result` unchanged. ADD32/SUB32 behave identically in both builds.

## Test plan
- ADD32 `op_a`=0x0001_FFFF, `op_b`=0x0000_0001 → `done` in cycle 7, `result`=0x0002_0000. OP_HI drives opcode 01101.
- SUB32 0x0001_0000 − 0x0000_0001 → 0x0000_FFFF. OP_HI drives 01110.
- ADD32 0xFFFF_FFFF + 0x0000_0001 → 0x0000_0000 (wrap), `err`=0.
- Start an ADD32, pulse `start` again in cycle 3 with other data → ignored, first result correct. Then assert `rst` during OP_HI → next cycle IDLE, `busy`=0, `result`=0, bus NOP/0/0/0.
- With `ALU_SEQ_LOGIC_EN`: AND32 0xF0F0_1234 & 0xFF00_00FF → 0xF000_0034. Without it: the same command → one-cycle `err`, `busy` never high, `result` unchanged.
- Protocol monitor over all runs: never `alu_write`=1 with a non-NOP opcode. `alu_read`=1 only in the RD states.
